mult_div_seq: RTL

Iterative signed multiply/divide sequencer for the multicycle MIPS core. It accepts a MULT or DIV request from the main control unit and runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles. It then presents HI/LO results with a one-cycle write strobe. While it runs it asserts busy so the control unit can hold in a wait state.

---
 rtl/mult_div_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mult_div_seq.sv
// Iterative signed multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULT_DIV_DIVZERO_EXC_EN to short-circuit divide-by-zero into a div_zero pulse.
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, MULT_RUN, DIV_RUN, DIV_FIX, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, mag;
    logic             neg_q, neg_r;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_r, div_t;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic               div_ok;

    assign a_mag = op_a[WIDTH-1] ? -op_a : op_a;
    assign b_mag = op_b[WIDTH-1] ? -op_b : op_b;

    // Multiply: acc_lo holds the remaining multiplier bits, product shifts in from the top.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag} : '0);
    assign prod    = {mul_sum, acc_lo[WIDTH-1:1]};
    assign prod_s  = neg_q ? -prod : prod;

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign div_r  = {acc_hi, acc_lo[WIDTH-1]};
    assign div_t  = div_r - {1'b0, mag};
    assign div_ok = ~div_t[WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            mag     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hilo_we <= 1'b0;
            hi_out  <= '0;
            lo_out  <= '0;
`ifdef MULT_DIV_DIVZERO_EXC_EN
            div_zero <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            hilo_we <= 1'b0;
`ifdef MULT_DIV_DIVZERO_EXC_EN
            div_zero <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    acc_hi <= '0;
                    if (start_mult) begin
                        state  <= MULT_RUN;
                        busy   <= 1'b1;
                        acc_lo <= b_mag;
                        mag    <= a_mag;
                        neg_q  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    end else if (start_div) begin
`ifdef MULT_DIV_DIVZERO_EXC_EN
                        if (op_b == '0) begin
                            state    <= DONE;
                            busy     <= 1'b1;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else
`endif
                        begin
                            state  <= DIV_RUN;
                            busy   <= 1'b1;
                            acc_lo <= a_mag;
                            mag    <= b_mag;
                            neg_q  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                            neg_r  <= op_a[WIDTH-1];
                        end
                    end
                end
                MULT_RUN: begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        hilo_we <= 1'b1;
                        hi_out  <= prod_s[2*WIDTH-1:WIDTH];
                        lo_out  <= prod_s[WIDTH-1:0];
                    end
                end
                DIV_RUN: begin
                    acc_hi <= div_ok ? div_t[WIDTH-1:0] : div_r[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) state <= DIV_FIX;
                end
                DIV_FIX: begin
                    state   <= DONE;
                    done    <= 1'b1;
                    hilo_we <= 1'b1;
                    hi_out  <= neg_r ? -acc_hi : acc_hi;
                    lo_out  <= neg_q ? -acc_lo : acc_lo;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef MULT_DIV_DIVZERO_EXC_EN
    assign div_zero = 1'b0;
`endif

endmodule
